// File: rtl/avalon_dpram.sv
// Dual-port Avalon-MM on-chip RAM: two independent slave ports, byte-lane writes,
// pipelined reads (1 or 2 cycles) with readdatavalid and a registered write-collision flag.
module avalon_dpram #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 14,
    parameter int DEPTH        = 10000,
    parameter int READ_LATENCY = 1,
    parameter int RDW_NEW_DATA = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clken,
    input  logic [ADDR_WIDTH-1:0]   a_address,
    input  logic                    a_chipselect,
    input  logic                    a_read,
    input  logic                    a_write,
    input  logic [DATA_WIDTH/8-1:0] a_byteenable,
    input  logic [DATA_WIDTH-1:0]   a_writedata,
    output logic [DATA_WIDTH-1:0]   a_readdata,
    output logic                    a_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]   b_address,
    input  logic                    b_chipselect,
    input  logic                    b_read,
    input  logic                    b_write,
    input  logic [DATA_WIDTH/8-1:0] b_byteenable,
    input  logic [DATA_WIDTH-1:0]   b_writedata,
    output logic [DATA_WIDTH-1:0]   b_readdata,
    output logic                    b_readdatavalid,
    output logic                    collision
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    // Handshake: no waitrequest; a request is taken in any cycle with clken=1.
    // A read with write also asserted is treated as a write only.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic a_in_range, b_in_range;
    logic a_wr_ok, b_wr_ok, a_rd_acc, b_rd_acc;
    logic [ADDR_WIDTH-1:0] a_idx, b_idx;
    logic [DATA_WIDTH-1:0] a_rdata_d, b_rdata_d;
    logic [DATA_WIDTH-1:0] a_rdata1_q, b_rdata1_q;
    logic a_valid1_q, b_valid1_q, coll_q;

    assign a_in_range = {1'b0, a_address} < DEPTH_W;
    assign b_in_range = {1'b0, b_address} < DEPTH_W;
    assign a_idx      = a_in_range ? a_address : '0;
    assign b_idx      = b_in_range ? b_address : '0;
    assign a_wr_ok    = clken & a_chipselect & a_write & a_in_range;
    assign b_wr_ok    = clken & b_chipselect & b_write & b_in_range;
    assign a_rd_acc   = clken & a_chipselect & a_read & ~a_write;
    assign b_rd_acc   = clken & b_chipselect & b_read & ~b_write;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NB-1:0]         be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    // Out-of-range reads return zero; the other port's same-cycle write is
    // merged in only when new-data read-during-write is selected.
    always_comb begin
        a_rdata_d = '0;
        if (a_in_range) begin
            a_rdata_d = mem[a_idx];
            if (RDW_NEW_DATA != 0 && b_wr_ok && (b_address == a_address))
                a_rdata_d = merge_bytes(mem[a_idx], b_writedata, b_byteenable);
        end
    end

    always_comb begin
        b_rdata_d = '0;
        if (b_in_range) begin
            b_rdata_d = mem[b_idx];
            if (RDW_NEW_DATA != 0 && a_wr_ok && (a_address == b_address))
                b_rdata_d = merge_bytes(mem[b_idx], a_writedata, a_byteenable);
        end
    end

    // Port A lanes are written last so they win on a same-address collision.
    always_ff @(posedge clk) begin
        if (b_wr_ok) begin
            for (int i = 0; i < NB; i++)
                if (b_byteenable[i]) mem[b_idx][8*i +: 8] <= b_writedata[8*i +: 8];
        end
        if (a_wr_ok) begin
            for (int i = 0; i < NB; i++)
                if (a_byteenable[i]) mem[a_idx][8*i +: 8] <= a_writedata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_valid1_q <= 1'b0;
            b_valid1_q <= 1'b0;
            a_rdata1_q <= '0;
            b_rdata1_q <= '0;
            coll_q     <= 1'b0;
        end else if (clken) begin
            a_valid1_q <= a_rd_acc;
            b_valid1_q <= b_rd_acc;
            if (a_rd_acc) a_rdata1_q <= a_rdata_d;
            if (b_rd_acc) b_rdata1_q <= b_rdata_d;
            coll_q     <= a_wr_ok & b_wr_ok & (a_address == b_address);
        end
    end

    assign collision = coll_q;

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  a_valid2_q, b_valid2_q;
        logic [DATA_WIDTH-1:0] a_rdata2_q, b_rdata2_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                a_valid2_q <= 1'b0;
                b_valid2_q <= 1'b0;
                a_rdata2_q <= '0;
                b_rdata2_q <= '0;
            end else if (clken) begin
                a_valid2_q <= a_valid1_q;
                b_valid2_q <= b_valid1_q;
                if (a_valid1_q) a_rdata2_q <= a_rdata1_q;
                if (b_valid1_q) b_rdata2_q <= b_rdata1_q;
            end
        end

        assign a_readdata      = a_rdata2_q;
        assign a_readdatavalid = a_valid2_q;
        assign b_readdata      = b_rdata2_q;
        assign b_readdatavalid = b_valid2_q;
    end else begin : g_lat1
        assign a_readdata      = a_rdata1_q;
        assign a_readdatavalid = a_valid1_q;
        assign b_readdata      = b_rdata1_q;
        assign b_readdatavalid = b_valid1_q;
    end
endmodule
